// File: rtl/icache_assoc.sv
`default_nettype none
// ============================================================================
//  Module      : icache_assoc
//  Description : N-way set-associative read-only instruction cache with
//                dual-word hit path, burst line refill, tree pseudo-LRU
//                replacement and whole-cache invalidate.
//  Revision    : 1.0 - initial release
// ============================================================================
module icache_assoc #(
    parameter int WAYS       = 2,
    parameter int SETS       = 128,
    parameter int LINE_WORDS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [31:0] addr_psy,
    input  logic        invalidate,
    output logic [31:0] data,
    output logic [31:0] data2,
    output logic        data_ok,
    output logic        data1_ok,
    output logic        data2_ok,
    output logic [31:0] addr_req,
    output logic        read_req,
    input  logic        req_ok,
    input  logic [31:0] read_data,
    input  logic        read_valid,
    input  logic        read_last
);

    localparam int OFF_W  = $clog2(LINE_WORDS);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = 30 - OFF_W - IDX_W;
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int PLRU_W = (WAYS > 1) ? WAYS - 1 : 1;
    localparam int DEPTH  = SETS * LINE_WORDS;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SHAK = 2'd1;
    localparam logic [1:0] S_RFIL = 2'd2;

    // Storage
    logic [TAG_W-1:0]  r_tag   [WAYS][SETS];
    logic [SETS-1:0]   r_valid [WAYS];
    logic [31:0]       r_mem   [WAYS][DEPTH];
    logic [PLRU_W-1:0] r_plru  [SETS];

    // Control state
    logic [1:0]             r_state;
    logic [1:0]             w_state_nxt;
    logic [TAG_W+IDX_W-1:0] r_pend;
    logic [WAY_W-1:0]       r_victim;
    logic [OFF_W-1:0]       r_cnt;
    logic                   r_inv_pend;

    // Address decode of the live fetch and of the pending refill
    logic [TAG_W-1:0] w_tag;
    logic [IDX_W-1:0] w_idx;
    logic [OFF_W-1:0] w_off;
    logic [OFF_W-1:0] w_off_nxt;
    logic [TAG_W-1:0] w_ptag;
    logic [IDX_W-1:0] w_pidx;
    logic             w_unused;

    assign w_tag     = addr_psy[31 -: TAG_W];
    assign w_idx     = addr_psy[OFF_W+2 +: IDX_W];
    assign w_off     = addr_psy[2 +: OFF_W];
    assign w_off_nxt = w_off + OFF_W'(1);
    assign w_ptag    = r_pend[TAG_W+IDX_W-1 -: TAG_W];
    assign w_pidx    = r_pend[IDX_W-1:0];
    assign w_unused  = ^addr_psy[1:0];

    // Victim from tree bits: bit0 picks the half, bit1/bit2 pick within it
    function automatic logic [WAY_W-1:0] plru_victim(input logic [PLRU_W-1:0] b);
        logic [2:0] p;
        logic [1:0] v;
        p = 3'(b);
        v = 2'd0;
        if (WAYS == 2)
            v = {1'b0, p[0]};
        else if (WAYS == 4)
            v = p[0] ? {1'b1, p[2]} : {1'b0, p[1]};
        return WAY_W'(v);
    endfunction

    // Point the tree bits on the accessed way's path away from it
    function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] b,
                                                     input logic [WAY_W-1:0]  w);
        logic [2:0] p;
        logic [1:0] ww;
        p  = 3'(b);
        ww = 2'(w);
        if (WAYS == 2) begin
            p[0] = ~ww[0];
        end else if (WAYS == 4) begin
            p[0] = ~ww[1];
            if (ww[1]) p[2] = ~ww[0];
            else       p[1] = ~ww[0];
        end
        return PLRU_W'(p);
    endfunction

    // Per-way tag compare
    logic [WAYS-1:0] w_hit_vec;
    generate
        for (genvar g = 0; g < WAYS; g++) begin : g_hit
            assign w_hit_vec[g] = r_valid[g][w_idx] && (r_tag[g][w_idx] == w_tag);
        end
    endgenerate

    // Lowest-numbered matching way wins
    logic             w_hit;
    logic [WAY_W-1:0] w_hit_way;
    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (w_hit_vec[w]) begin
                w_hit     = 1'b1;
                w_hit_way = WAY_W'(w);
            end
        end
    end

    // Victim: lowest invalid way in the set, otherwise the PLRU choice
    logic [WAY_W-1:0] w_victim;
    logic             w_inv_found;
    always_comb begin
        w_victim    = plru_victim(r_plru[w_idx]);
        w_inv_found = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!w_inv_found && !r_valid[w][w_idx]) begin
                w_victim    = WAY_W'(w);
                w_inv_found = 1'b1;
            end
        end
    end

    // Asynchronous dual-word read from the hit way
    logic [31:0] w_rd1;
    logic [31:0] w_rd2;
    assign w_rd1 = r_mem[w_hit_way][{w_idx, w_off}];
    assign w_rd2 = r_mem[w_hit_way][{w_idx, w_off_nxt}];

    // Line data and tag written on refill beats; arrays are not reset
    always_ff @(posedge clk) begin
        if (!rst && r_state == S_RFIL && read_valid) begin
            r_mem[r_victim][{w_pidx, r_cnt}] <= read_data;
            if (read_last) r_tag[r_victim][w_pidx] <= w_ptag;
        end
    end

    // FSM state, valid bits, PLRU and refill bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_pend     <= '0;
            r_victim   <= '0;
            r_cnt      <= '0;
            r_inv_pend <= 1'b0;
            for (int w = 0; w < WAYS; w++) r_valid[w] <= '0;
            for (int s = 0; s < SETS; s++) r_plru[s] <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (enable && w_hit)
                        r_plru[w_idx] <= plru_touch(r_plru[w_idx], w_hit_way);
                    if (enable && !w_hit) begin
                        r_pend   <= {w_tag, w_idx};
                        r_victim <= w_victim;
                    end
                    if (invalidate)
                        for (int w = 0; w < WAYS; w++) r_valid[w] <= '0;
                end
                S_SHAK: begin
                    r_cnt <= '0;
                    if (invalidate) r_inv_pend <= 1'b1;
                end
                S_RFIL: begin
                    if (invalidate) r_inv_pend <= 1'b1;
                    if (read_valid) begin
                        r_cnt <= r_cnt + OFF_W'(1);
                        if (read_last) begin
                            r_valid[r_victim][w_pidx] <= 1'b1;
                            r_plru[w_pidx] <= plru_touch(r_plru[w_pidx], r_victim);
                            r_inv_pend     <= 1'b0;
                            // A deferred invalidate lands after the valid set,
                            // so the freshly filled line is cleared as well
                            if (r_inv_pend || invalidate)
                                for (int w = 0; w < WAYS; w++) r_valid[w] <= '0;
                        end
                    end
                end
                default: r_cnt <= '0;
            endcase
        end
    end

    // Next-state and output decode; outputs held at zero during reset
    always_comb begin
        w_state_nxt = r_state;
        read_req    = 1'b0;
        addr_req    = '0;
        data_ok     = 1'b0;
        data1_ok    = 1'b0;
        data2_ok    = 1'b0;
        data        = '0;
        data2       = '0;
        if (!rst) begin
            case (r_state)
                S_IDLE: begin
                    if (!enable || w_hit) begin
                        data_ok  = 1'b1;
                        data1_ok = 1'b1;
                        data2_ok = (w_off != OFF_W'(LINE_WORDS - 1));
                        data     = w_rd1;
                        data2    = w_rd2;
                    end else begin
                        read_req    = 1'b1;
                        addr_req    = {w_tag, w_idx, {(OFF_W+2){1'b0}}};
                        w_state_nxt = req_ok ? S_RFIL : S_SHAK;
                    end
                end
                S_SHAK: begin
                    read_req = 1'b1;
                    addr_req = {r_pend, {(OFF_W+2){1'b0}}};
                    if (req_ok) w_state_nxt = S_RFIL;
                end
                S_RFIL: begin
                    if (read_valid && read_last) w_state_nxt = S_IDLE;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_icache_assoc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_icache_assoc
//  Description : Directed self-checking bench for icache_assoc; a default
//                2-way instance and a 4-way/64-set/8-word instance share the
//                refill-side inputs, each with its own enable.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_icache_assoc;

    logic        clk = 1'b0;
    logic        rst;
    logic        en0, en1;
    logic [31:0] addr_psy;
    logic        invalidate;
    logic        req_ok;
    logic [31:0] read_data;
    logic        read_valid;
    logic        read_last;
    logic        sel;

    logic [31:0] data_0, data2_0, areq_0;
    logic        ok_0, ok1_0, ok2_0, rreq_0;
    logic [31:0] data_4, data2_4, areq_4;
    logic        ok_4, ok1_4, ok2_4, rreq_4;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    icache_assoc dut (
        .clk(clk), .rst(rst), .enable(en0), .addr_psy(addr_psy),
        .invalidate(invalidate), .data(data_0), .data2(data2_0),
        .data_ok(ok_0), .data1_ok(ok1_0), .data2_ok(ok2_0),
        .addr_req(areq_0), .read_req(rreq_0), .req_ok(req_ok),
        .read_data(read_data), .read_valid(read_valid), .read_last(read_last)
    );

    icache_assoc #(.WAYS(4), .SETS(64), .LINE_WORDS(8)) dut4 (
        .clk(clk), .rst(rst), .enable(en1), .addr_psy(addr_psy),
        .invalidate(invalidate), .data(data_4), .data2(data2_4),
        .data_ok(ok_4), .data1_ok(ok1_4), .data2_ok(ok2_4),
        .addr_req(areq_4), .read_req(rreq_4), .req_ok(req_ok),
        .read_data(read_data), .read_valid(read_valid), .read_last(read_last)
    );

    // Outputs of whichever instance is under test
    logic [31:0] m_data, m_data2, m_areq;
    logic        m_ok, m_ok1, m_ok2, m_rreq;
    assign m_data  = sel ? data_4  : data_0;
    assign m_data2 = sel ? data2_4 : data2_0;
    assign m_areq  = sel ? areq_4  : areq_0;
    assign m_ok    = sel ? ok_4    : ok_0;
    assign m_ok1   = sel ? ok1_4   : ok1_0;
    assign m_ok2   = sel ? ok2_4   : ok2_0;
    assign m_rreq  = sel ? rreq_4  : rreq_0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_en(input logic v);
        if (sel) en1 = v;
        else     en0 = v;
    endtask

    // One lookup; hold keeps enable high through the edge (PLRU touch)
    task automatic probe(input string tag, input logic [31:0] a, input logic hit,
                         input logic [31:0] exp_d, input logic hold);
        @(negedge clk);
        addr_psy = a;
        set_en(1'b1);
        #1;
        chk({tag, "_ok"}, 32'(m_ok), 32'(hit));
        if (hit) chk({tag, "_data"}, m_data, exp_d);
        else     chk({tag, "_rreq"}, 32'(m_rreq), 32'd1);
        if (!hold) set_en(1'b0);
    endtask

    // Miss, two cycles of handshake, req_ok in cycle 3, then a full burst
    task automatic fill(input string tag, input logic [31:0] a, input logic [31:0] base,
                        input int inv_beat);
        int          nb;
        logic [31:0] mask;
        nb   = sel ? 8 : 16;
        mask = sel ? ~32'h1F : ~32'h3F;
        @(negedge clk);
        addr_psy = a;
        set_en(1'b1);
        req_ok = 1'b0;
        #1;
        chk({tag, "_rreq"}, 32'(m_rreq), 32'd1);
        chk({tag, "_areq"}, m_areq, a & mask);
        @(negedge clk);
        #1;
        chk({tag, "_shak"}, 32'(m_rreq), 32'd1);
        @(negedge clk);
        req_ok = 1'b1;
        for (int i = 0; i < nb; i++) begin
            @(negedge clk);
            req_ok     = 1'b0;
            read_valid = 1'b1;
            read_data  = base + 32'(i);
            read_last  = (i == nb - 1);
            invalidate = (i == inv_beat);
            if (i == 0) begin
                #1;
                chk({tag, "_rfil_rreq"}, 32'(m_rreq), 32'd0);
            end
        end
        @(negedge clk);
        read_valid = 1'b0;
        read_last  = 1'b0;
        invalidate = 1'b0;
        set_en(1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; en0 = 1'b0; en1 = 1'b0; addr_psy = '0; invalidate = 1'b0;
        req_ok = 1'b0; read_data = '0; read_valid = 1'b0; read_last = 1'b0; sel = 1'b0;

        // Reset state
        @(negedge clk);
        #1;
        chk("rst_rreq", 32'(m_rreq), 32'd0);
        chk("rst_areq", m_areq, 32'd0);
        chk("rst_ok",   32'(m_ok),   32'd0);
        chk("rst_data", m_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Cold miss and dual-word hit
        fill("cold", 32'h0000_1040, 32'h100, -1);
        @(negedge clk);
        addr_psy = 32'h0000_1040;
        en0 = 1'b1;
        #1;
        chk("cold_ok",    32'(m_ok),  32'd1);
        chk("cold_ok1",   32'(m_ok1), 32'd1);
        chk("cold_data",  m_data,  32'h100);
        chk("cold_data2", m_data2, 32'h101);
        chk("cold_ok2",   32'(m_ok2), 32'd1);
        en0 = 1'b0;

        // Last word of line: no second word
        probe("last", 32'h0000_107C, 1'b1, 32'h10F, 1'b0);
        chk("last_ok2", 32'(m_ok2), 32'd0);

        // Same-set conflict
        fill("conf", 32'h0000_3040, 32'h300, -1);
        probe("h1040a", 32'h0000_1040, 1'b1, 32'h100, 1'b0);
        probe("h3044",  32'h0000_3044, 1'b1, 32'h301, 1'b0);
        probe("acc1040", 32'h0000_1040, 1'b1, 32'h100, 1'b1);
        fill("m5040", 32'h0000_5040, 32'h500, -1);
        probe("h1040b", 32'h0000_1040, 1'b1, 32'h100, 1'b0);
        probe("h5048",  32'h0000_5048, 1'b1, 32'h502, 1'b0);
        probe("m3040",  32'h0000_3040, 1'b0, 32'h0,   1'b0);

        // Invalidate during refill
        fill("inv", 32'h0000_2080, 32'h800, 5);
        probe("inv2080", 32'h0000_2080, 1'b0, 32'h0, 1'b0);
        probe("inv1040", 32'h0000_1040, 1'b0, 32'h0, 1'b0);
        probe("inv5040", 32'h0000_5040, 1'b0, 32'h0, 1'b0);

        // Reset in the middle of a refill
        @(negedge clk);
        addr_psy = 32'h0000_1040;
        en0 = 1'b1;
        req_ok = 1'b1;
        #1;
        chk("rs_miss", 32'(m_rreq), 32'd1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            req_ok     = 1'b0;
            read_valid = 1'b1;
            read_data  = 32'hA00 + 32'(i);
        end
        @(negedge clk);
        rst = 1'b1;
        read_data = 32'hA08;
        @(negedge clk);
        read_data = 32'hA09;
        #1;
        chk("rs_idle_rreq", 32'(m_rreq), 32'd0);
        chk("rs_idle_ok",   32'(m_ok),   32'd0);
        @(negedge clk);
        rst = 1'b0;
        read_data = 32'hA0A;
        read_last = 1'b1;
        #1;
        chk("rs_rereq", 32'(m_rreq), 32'd1);
        chk("rs_areq",  m_areq, 32'h0000_1040);
        chk("rs_ok",    32'(m_ok), 32'd0);
        en0 = 1'b0;
        @(negedge clk);
        read_valid = 1'b0;
        read_last  = 1'b0;
        probe("rs_after", 32'h0000_1040, 1'b0, 32'h0, 1'b0);

        // 4-way tree PLRU: five tags into set 3
        sel = 1'b1;
        for (int t = 1; t <= 5; t++)
            fill("w4fill", 32'h60 + 32'(t) * 32'h800, 32'(t) << 12, -1);
        probe("w4_t1", 32'h0000_0864, 1'b0, 32'h0, 1'b0);
        for (int t = 2; t <= 5; t++)
            probe("w4_hit", 32'h64 + 32'(t) * 32'h800, 1'b1, (32'(t) << 12) + 32'd1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
